// File: rtl/regfile_port_sequencer.sv
// Purpose: serialises decode rs/rt reads and writeback writes onto one register-file port.
// Latency: 1 + RD_LAT*(non-skipped reads) cycles from IDLE acceptance to id_rsp_valid (+1 if a write goes first).
// Backpressure: wb_ready only in IDLE; decode is stalled (id_stall) until its response pulse.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   id_req_valid/id_rs/id_rt/
//   id_need_rt                      decode read request, held stable until id_rsp_valid
//   id_rsp_valid/data1/data2/
//   flag1/flag2/hazardDetected      decode response, valid on the id_rsp_valid pulse
//   id_stall                        decode stall
//   wb_valid/wb_idx/wb_data/wb_ready writeback handshake
//   rf_index/rf_value_in/rf_read_en/
//   rf_write_en/rf_value_out/
//   rf_flag_out                     single register-file port
module regfile_port_sequencer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_req_valid,
  input  logic [IDX_W-1:0]  id_rs,
  input  logic [IDX_W-1:0]  id_rt,
  input  logic              id_need_rt,
  output logic              id_rsp_valid,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              flag1,
  output logic              flag2,
  output logic              hazardDetected,
  output logic              id_stall,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic [IDX_W-1:0]  rf_index,
  output logic [DATA_W-1:0] rf_value_in,
  output logic              rf_read_en,
  output logic              rf_write_en,
  input  logic [DATA_W-1:0] rf_value_out,
  input  logic              rf_flag_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_A,
    S_RD_B,
    S_RESP
  } state_t;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  state_t              w_first_in;
  logic [CNT_W-1:0]    r_lat_cnt;
  logic [IDX_W-1:0]    r_wb_idx;
  logic [DATA_W-1:0]   r_wb_data;
  logic [IDX_W-1:0]    r_rs;
  logic [IDX_W-1:0]    r_rt;
  logic                r_need_rt;
  logic [DATA_W-1:0]   r_data1;
  logic [DATA_W-1:0]   r_data2;
  logic                r_flag1;
  logic                r_flag2;

  logic w_skip_a_in;
  logic w_skip_b_in;
  logic w_skip_b_q;
  logic w_take_wb;
  logic w_take_req;
  logic w_reading;
  logic w_rd_last;

  // r0 reads never touch the port; rt is also skipped when the instruction has no rt operand.
  assign w_skip_a_in = (id_rs == '0);
  assign w_skip_b_in = !id_need_rt || (id_rt == '0);
  assign w_skip_b_q  = !r_need_rt || (r_rt == '0);

  // First state of a read sequence; skipped reads collapse so RESP can follow acceptance directly.
  always_comb begin
    w_first_in = S_RESP;
    if (!w_skip_a_in) begin
      w_first_in = S_RD_A;
    end else if (!w_skip_b_in) begin
      w_first_in = S_RD_B;
    end
  end

  // Writeback wins in IDLE; a request still pending after a write is taken straight from WRITE.
  assign w_take_wb  = (r_state == S_IDLE) && wb_valid;
  assign w_take_req = ((r_state == S_IDLE) && !wb_valid && id_req_valid) ||
                      ((r_state == S_WRITE) && id_req_valid);
  assign w_reading  = (r_state == S_RD_A) || (r_state == S_RD_B);
  assign w_rd_last  = (r_lat_cnt == LAST_CNT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (wb_valid) begin
          w_next = S_WRITE;
        end else if (id_req_valid) begin
          w_next = w_first_in;
        end
      end
      S_WRITE: begin
        w_next = id_req_valid ? w_first_in : S_IDLE;
      end
      S_RD_A: begin
        if (w_rd_last) begin
          w_next = w_skip_b_q ? S_RESP : S_RD_B;
        end
      end
      S_RD_B: begin
        if (w_rd_last) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_wb_idx  <= '0;
      r_wb_data <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_need_rt <= 1'b0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_flag1   <= 1'b0;
      r_flag2   <= 1'b0;
    end else begin
      r_state <= w_next;

      // Counts cycles spent in the current read state; any state change restarts it.
      if (w_next != r_state) begin
        r_lat_cnt <= '0;
      end else if (w_reading) begin
        r_lat_cnt <= r_lat_cnt + CNT_W'(1);
      end

      if (w_take_wb) begin
        r_wb_idx  <= wb_idx;
        r_wb_data <= wb_data;
      end

      if (w_take_req) begin
        r_rs      <= id_rs;
        r_rt      <= id_rt;
        r_need_rt <= id_need_rt;
        if (w_skip_a_in) begin
          r_data1 <= '0;
          r_flag1 <= 1'b1;
        end
        if (w_skip_b_in) begin
          r_data2 <= '0;
          r_flag2 <= 1'b1;
        end
      end

      if ((r_state == S_RD_A) && w_rd_last) begin
        r_data1 <= rf_value_out;
        r_flag1 <= rf_flag_out;
      end
      if ((r_state == S_RD_B) && w_rd_last) begin
        r_data2 <= rf_value_out;
        r_flag2 <= rf_flag_out;
      end
    end
  end

  // Port drive is a pure function of state and latched operands, so a reset leaves it idle at once.
  always_comb begin
    rf_index    = '0;
    rf_value_in = '0;
    rf_read_en  = 1'b0;
    rf_write_en = 1'b0;
    case (r_state)
      S_WRITE: begin
        rf_write_en = 1'b1;
        rf_index    = r_wb_idx;
        rf_value_in = r_wb_data;
      end
      S_RD_A: begin
        rf_read_en = 1'b1;
        rf_index   = r_rs;
      end
      S_RD_B: begin
        rf_read_en = 1'b1;
        rf_index   = r_rt;
      end
      default: begin
        rf_index = '0;
      end
    endcase
  end

  assign wb_ready       = (r_state == S_IDLE);
  assign id_rsp_valid   = (r_state == S_RESP);
  assign hazardDetected = (r_state == S_RESP) && (!r_flag1 || (r_need_rt && !r_flag2));
  assign id_stall       = id_req_valid && !id_rsp_valid;
  assign data1          = r_data1;
  assign data2          = r_data2;
  assign flag1          = r_flag1;
  assign flag2          = r_flag2;

endmodule
